// File: rtl/stg_pkg.sv
// Shared sprite/game definitions: player state, playfield limits,
// frame counter width. Used by player, bullet, HUD and hit logic.
package stg_pkg;

   typedef enum logic [1:0] {
      ALIVE,
      HIT,
      INVULN,
      DEAD
   } state_t;

   localparam int MAX_X = 384;
   localparam int MAX_Y = 448;
   localparam int CNT_W = 8;

   // True when a scan position lies inside the visible playfield.
   function automatic logic in_field(
      input logic [9:0] px,
      input logic [9:0] py
   );
      return (px < 10'(MAX_X)) && (py < 10'(MAX_Y));
   endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter of frames; load wins over tick,
// and the count holds at zero instead of wrapping.
module frame_down_counter
   import stg_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   // Reload or count down one frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/player_hit_ctrl.sv
// Player hit detection: per-frame overlap resolve, then the
// hit / invulnerability / death sequence plus the lives counter.
module player_hit_ctrl #(
   parameter int LIVES_INIT    = 3,
   parameter int HIT_FRAMES    = 30,
   parameter int INVULN_FRAMES = 120,
   parameter int MAX_X         = stg_pkg::MAX_X,
   parameter int MAX_Y         = stg_pkg::MAX_Y
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       player_on,
   input  logic       bullet_on,
   input  logic       frame_tick,
   output logic       collision,
   output logic       invuln_blink,
   output logic       hit_pulse,
   output logic       bullet_clear,
   output logic [2:0] lives,
   output logic       game_over
);

   import stg_pkg::*;

   localparam logic [9:0] X_LIM = 10'(MAX_X);
   localparam logic [9:0] Y_LIM = 10'(MAX_Y);
   localparam logic [2:0] L_INIT = 3'(LIVES_INIT);
   localparam logic [CNT_W-1:0] HIT_LD = CNT_W'(HIT_FRAMES - 1);
   localparam logic [CNT_W-1:0] INV_LD = CNT_W'(INVULN_FRAMES - 1);

   state_t           state;
   logic             latch;
   logic             overlap;
   logic             hit;
   logic             ld;
   logic [CNT_W-1:0] ld_val;
   logic             dec;
   logic [CNT_W-1:0] cnt;
   logic             zero;

   assign overlap = player_on && bullet_on
                 && (x < X_LIM) && (y < Y_LIM);

   // An overlap on the tick cycle still belongs to the ending frame.
   assign hit = latch || overlap;

   frame_down_counter u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (ld_val),
      .tick     (dec),
      .count    (cnt),
      .zero     (zero)
   );

   // Counter control: reload on state entry, count down per frame.
   always_comb begin
      ld     = 1'b0;
      ld_val = '0;
      dec    = 1'b0;
      if (frame_tick) begin
         unique case (state)
            ALIVE: begin
               if (hit && lives != 3'd1) begin
                  ld     = 1'b1;
                  ld_val = HIT_LD;
               end
            end
            HIT: begin
               if (zero) begin
                  ld     = 1'b1;
                  ld_val = INV_LD;
               end else begin
                  dec = 1'b1;
               end
            end
            INVULN: dec = !zero;
            DEAD: ;
            default: ;
         endcase
      end
   end

   // Overlap latch: accumulates over a frame only while ALIVE.
   always_ff @(posedge clk) begin
      if (reset) begin
         latch <= 1'b0;
      end else if (state != ALIVE || frame_tick) begin
         latch <= 1'b0;
      end else if (overlap) begin
         latch <= 1'b1;
      end
   end

   // Hit sequence FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ALIVE;
         lives        <= L_INIT;
         collision    <= 1'b0;
         invuln_blink <= 1'b0;
         hit_pulse    <= 1'b0;
         bullet_clear <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         hit_pulse    <= 1'b0;
         bullet_clear <= 1'b0;
         collision    <= (state == HIT) || (state == DEAD);
         game_over    <= (state == DEAD);
         invuln_blink <= (state == INVULN) && cnt[3];
         if (frame_tick) begin
            unique case (state)
               ALIVE: begin
                  if (hit && lives != 3'd0) begin
                     lives        <= lives - 3'd1;
                     hit_pulse    <= 1'b1;
                     bullet_clear <= 1'b1;
                     state        <= (lives == 3'd1) ? DEAD : HIT;
                  end
               end
               HIT: begin
                  if (zero) state <= INVULN;
               end
               INVULN: begin
                  if (zero) state <= ALIVE;
               end
               DEAD: ;
               default: state <= ALIVE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_player_hit_ctrl.sv
// Scoreboard bench for player_hit_ctrl: a frame-level model
// queues expected outputs per tick, scenario tasks compare them.
`timescale 1ns/1ps
module tb_player_hit_ctrl;

   localparam int L_INIT = 3;
   localparam int HIT_F  = 30;
   localparam int INV_F  = 120;

   typedef enum int {S_ALIVE, S_HIT, S_INV, S_DEAD} mstate_t;

   typedef struct packed {
      logic       hp;
      logic       bc;
      logic       hp2;
      logic [2:0] lives;
      logic       coll;
      logic       blink;
      logic       go;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       player_on = 1'b0;
   logic       bullet_on = 1'b0;
   logic       frame_tick = 1'b0;
   logic       collision;
   logic       invuln_blink;
   logic       hit_pulse;
   logic       bullet_clear;
   logic [2:0] lives;
   logic       game_over;

   int nvec = 0;
   int nerr = 0;

   obs_t sb[$];

   mstate_t m_state;
   int      m_lives;
   int      m_cnt;
   bit      m_latch;

   player_hit_ctrl #(
      .LIVES_INIT    (L_INIT),
      .HIT_FRAMES    (HIT_F),
      .INVULN_FRAMES (INV_F),
      .MAX_X         (384),
      .MAX_Y         (448)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .x            (x),
      .y            (y),
      .player_on    (player_on),
      .bullet_on    (bullet_on),
      .frame_tick   (frame_tick),
      .collision    (collision),
      .invuln_blink (invuln_blink),
      .hit_pulse    (hit_pulse),
      .bullet_clear (bullet_clear),
      .lives        (lives),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   function automatic bit in_pf(int px, int py);
      return px < 384 && py < 448;
   endfunction

   function automatic obs_t model_out(bit hp);
      obs_t e;
      e.hp    = hp;
      e.bc    = hp;
      e.hp2   = 1'b0;
      e.lives = 3'(m_lives);
      e.coll  = (m_state == S_HIT) || (m_state == S_DEAD);
      e.blink = (m_state == S_INV) && ((m_cnt / 8) % 2 == 1);
      e.go    = (m_state == S_DEAD);
      return e;
   endfunction

   task automatic drive_idle();
      frame_tick = 1'b0;
      reset      = 1'b0;
      player_on  = 1'b0;
      bullet_on  = 1'b0;
      x          = '0;
      y          = '0;
   endtask

   task automatic sample(output obs_t o);
      @(posedge clk);
      #1;
      drive_idle();
      o.hp    = hit_pulse;
      o.bc    = bullet_clear;
      @(posedge clk);
      #1;
      o.hp2   = hit_pulse;
      o.lives = lives;
      o.coll  = collision;
      o.blink = invuln_blink;
      o.go    = game_over;
   endtask

   // One pixel cycle with both layers opaque at (px,py).
   task automatic pixel(input int px, input int py);
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      player_on = 1'b1;
      bullet_on = 1'b1;
      @(posedge clk);
      #1;
      drive_idle();
      if (m_state == S_ALIVE && in_pf(px, py))
         m_latch = 1'b1;
   endtask

   // Frame tick, optionally with an overlap in the same cycle.
   task automatic do_tick(input int px, input int py,
                          input bit ov, output obs_t o);
      bit hit;
      bit hp;
      hp  = 1'b0;
      hit = m_latch || (ov && in_pf(px, py));
      unique case (m_state)
         S_ALIVE: begin
            if (hit) begin
               hp = 1'b1;
               if (m_lives == 1) begin
                  m_state = S_DEAD;
               end else begin
                  m_state = S_HIT;
                  m_cnt   = HIT_F - 1;
               end
               m_lives = m_lives - 1;
            end
         end
         S_HIT: begin
            if (m_cnt == 0) begin
               m_state = S_INV;
               m_cnt   = INV_F - 1;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
         S_INV: begin
            if (m_cnt == 0) m_state = S_ALIVE;
            else m_cnt = m_cnt - 1;
         end
         S_DEAD: ;
         default: ;
      endcase
      m_latch = 1'b0;
      sb.push_back(model_out(hp));
      @(negedge clk);
      frame_tick = 1'b1;
      x = 10'(px);
      y = 10'(py);
      player_on = ov;
      bullet_on = ov;
      sample(o);
   endtask

   // Reset pulse, with a tick and overlap racing it.
   task automatic do_reset(output obs_t o);
      m_state = S_ALIVE;
      m_lives = L_INIT;
      m_cnt   = 0;
      m_latch = 1'b0;
      sb.push_back(model_out(1'b0));
      @(negedge clk);
      reset      = 1'b1;
      frame_tick = 1'b1;
      x          = 10'd100;
      y          = 10'd200;
      player_on  = 1'b1;
      bullet_on  = 1'b1;
      sample(o);
   endtask

   task automatic test_reset();
      obs_t o;
      obs_t e;
      do_reset(o);
      e = sb.pop_front();
      nvec++;
      if (o !== e) begin
         $display("FAIL reset got=%h want=%h", o, e);
         nerr++;
      end
      nvec++;
      if (o.lives !== 3'd3) begin
         $display("FAIL reset_lives got=%0d want=3", o.lives);
         nerr++;
      end
   endtask

   task automatic test_first_hit();
      obs_t o;
      obs_t e;
      pixel(100, 200);
      do_tick(0, 0, 1'b0, o);
      e = sb.pop_front();
      nvec++;
      if (o !== e) begin
         $display("FAIL first_hit got=%h want=%h", o, e);
         nerr++;
      end
      nvec++;
      if (o.lives !== 3'd2 || o.hp !== 1'b1 || o.coll !== 1'b1) begin
         $display("FAIL first_hit_abs lives=%0d hp=%b coll=%b want 2 1 1",
                  o.lives, o.hp, o.coll);
         nerr++;
      end
   endtask

   // Hit flash then invulnerability, with overlaps every frame.
   task automatic test_recovery();
      obs_t o;
      obs_t e;
      int   toggles;
      logic prev;
      toggles = 0;
      prev    = 1'b0;
      for (int i = 0; i < HIT_F + INV_F; i++) begin
         pixel(150, 150);
         do_tick(150, 150, 1'b1, o);
         e = sb.pop_front();
         nvec++;
         if (o !== e) begin
            $display("FAIL recovery[%0d] got=%h want=%h", i, o, e);
            nerr++;
         end
         if (o.blink !== prev) toggles++;
         prev = o.blink;
      end
      nvec++;
      if (toggles < 10 || o.blink !== 1'b0 || o.lives !== 3'd2) begin
         $display("FAIL recovery_blink toggles=%0d blink=%b lives=%0d",
                  toggles, o.blink, o.lives);
         nerr++;
      end
      pixel(300, 400);
      do_tick(0, 0, 1'b0, o);
      e = sb.pop_front();
      nvec++;
      if (o !== e || o.lives !== 3'd1) begin
         $display("FAIL rehit got=%h want=%h", o, e);
         nerr++;
      end
   endtask

   task automatic test_boundary();
      obs_t o;
      obs_t e;
      test_reset();
      pixel(400, 100);
      pixel(384, 10);
      pixel(10, 448);
      do_tick(0, 0, 1'b0, o);
      e = sb.pop_front();
      nvec++;
      if (o !== e || o.lives !== 3'd3) begin
         $display("FAIL outside got=%h want=%h", o, e);
         nerr++;
      end
      do_tick(383, 447, 1'b1, o);
      e = sb.pop_front();
      nvec++;
      if (o !== e || o.lives !== 3'd2) begin
         $display("FAIL tick_overlap got=%h want=%h", o, e);
         nerr++;
      end
   endtask

   task automatic test_reset_mid_hit();
      obs_t o;
      obs_t e;
      for (int i = 0; i < 17; i++) begin
         do_tick(0, 0, 1'b0, o);
         e = sb.pop_front();
         nvec++;
         if (o !== e) begin
            $display("FAIL mid_hit[%0d] got=%h want=%h", i, o, e);
            nerr++;
         end
      end
      test_reset();
      do_tick(0, 0, 1'b0, o);
      e = sb.pop_front();
      nvec++;
      if (o !== e || o.hp !== 1'b0) begin
         $display("FAIL latch_clear got=%h want=%h", o, e);
         nerr++;
      end
   endtask

   // Three hits back to back through full recovery, then terminal.
   task automatic test_game_over();
      obs_t o;
      obs_t e;
      for (int h = 0; h < 3; h++) begin
         pixel(50 + h, 60);
         do_tick(0, 0, 1'b0, o);
         e = sb.pop_front();
         nvec++;
         if (o !== e) begin
            $display("FAIL go_hit[%0d] got=%h want=%h", h, o, e);
            nerr++;
         end
         if (h < 2) begin
            for (int i = 0; i < HIT_F + INV_F; i++) begin
               do_tick(0, 0, 1'b0, o);
               e = sb.pop_front();
               nvec++;
               if (o !== e) begin
                  $display("FAIL go_wait[%0d] got=%h want=%h", i, o, e);
                  nerr++;
               end
            end
         end
      end
      nvec++;
      if (o.lives !== 3'd0 || o.go !== 1'b1 || o.coll !== 1'b1) begin
         $display("FAIL dead lives=%0d go=%b coll=%b want 0 1 1",
                  o.lives, o.go, o.coll);
         nerr++;
      end
      for (int i = 0; i < 5; i++) begin
         pixel(100, 200);
         do_tick(100, 200, 1'b1, o);
         e = sb.pop_front();
         nvec++;
         if (o !== e) begin
            $display("FAIL dead_hold[%0d] got=%h want=%h", i, o, e);
            nerr++;
         end
      end
      test_reset();
   endtask

   initial begin
      drive_idle();
      m_state = S_ALIVE;
      m_lives = L_INIT;
      m_cnt   = 0;
      m_latch = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_first_hit();
      test_recovery();
      test_boundary();
      test_reset_mid_hit();
      test_game_over();
      nvec++;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_left got=%0d want=0", sb.size());
         nerr++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
